// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed per-channel spike counting, then a sequential scan that finds the highest-rate channel.
// Define SPIKE_DECODER_EDGE_EN to count only rising edges of each spike input instead of high levels.
module spike_rate_decoder #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8,
  parameter int WIN_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WIN_W-1:0]            win_len,
  input  logic [CHANNELS-1:0]         spikes,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(CHANNELS)-1:0] winner,
  output logic [CNT_W-1:0]            winner_count,
  output logic                        tie
);
  localparam int IDX_W = $clog2(CHANNELS);
  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;
  state_t state, state_next;
  logic [WIN_W-1:0]    win_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CNT_W-1:0]    cur;
  logic [CHANNELS-1:0] hit;
`ifdef SPIKE_DECODER_EDGE_EN
  logic [CHANNELS-1:0] prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= '0;
    else prev <= spikes;
  assign hit = spikes & ~prev;
`else
  assign hit = spikes;
`endif
  assign cur       = cnt[scan_idx];
  assign busy      = state != IDLE;
  assign res_valid = state == DONE;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? COUNT : IDLE;
      COUNT:   state_next = (win_cnt == WIN_W'(1)) ? SCAN : COUNT;
      SCAN:    state_next = (scan_idx == IDX_W'(CHANNELS - 1)) ? DONE : SCAN;
      DONE:    state_next = res_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  // A latched window of 0 wraps through the full 2^WIN_W range before reaching 1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      win_cnt      <= '0;
      scan_idx     <= '0;
      winner       <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        win_cnt  <= win_len;
        scan_idx <= '0;
        for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      end
      if (state == COUNT) begin
        win_cnt <= win_cnt - WIN_W'(1);
        for (int i = 0; i < CHANNELS; i++)
          if (hit[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
      end
      if (state == SCAN) begin
        scan_idx <= scan_idx + IDX_W'(1);
        if (scan_idx == '0 || cur > winner_count) begin
          winner       <= scan_idx;
          winner_count <= cur;
          tie          <= 1'b0;
        end else if (cur == winner_count) tie <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: randomized and directed windows checked against a counting/argmax reference model.
module tb_spike_rate_decoder;
  localparam int CH = 8;
`ifdef SPIKE_DECODER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n, start, res_ready, busy, res_valid, tie;
  logic [7:0] win_len, spikes, winner_count;
  logic [2:0] winner;
  logic [7:0] prev;
  int tests = 0, fails = 0;
  logic [2:0] ew;
  logic [7:0] ec;
  logic       et;

  spike_rate_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .spikes(spikes),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .winner(winner), .winner_count(winner_count), .tie(tie)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [7:0] s);
    spikes = s;
    @(posedge clk);
    prev = s;
    #1;
  endtask

  function automatic logic [7:0] gen(input int kind, input int c);
    case (kind)
      0: return 8'($urandom);
      1: return 8'h08;
      2: return (c >= 1 && c <= 8 && c % 2 == 1) ? 8'h24 : 8'h00;
      3: return 8'h80;
      4: return 8'h00;
      5: return 8'h02;
      default: return (c % 2 == 1) ? 8'h02 : 8'h00;
    endcase
  endfunction

  task automatic run_window(input int w, input int kind, input logic rdy, input string name,
                            output logic [2:0] xw, output logic [7:0] xc, output logic xt);
    int n [CH];
    int weff, k, best, nbest, first;
    logic [7:0] s, hit;
    weff = (w == 0) ? 256 : w;
    for (int i = 0; i < CH; i++) n[i] = 0;
    res_ready = rdy;
    start = 1'b1;
    win_len = 8'(w);
    tick(gen(kind, 0));
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy); end
    for (int c = 1; c <= weff; c++) begin
      s = gen(kind, c);
      hit = EDGE ? (s & ~prev) : s;
      for (int i = 0; i < CH; i++) if (hit[i] && n[i] < 255) n[i]++;
      tick(s);
    end
    k = 0;
    do begin tick(8'($urandom)); k++; end while (!res_valid && k < CH + 4);
    tests++; if (k !== CH) begin fails++; $display("FAIL %s latency: got %0d scan cycles expected %0d", name, k, CH); end
    best = -1; nbest = 0; first = 0;
    for (int i = 0; i < CH; i++)
      if (n[i] > best) begin best = n[i]; first = i; nbest = 1; end
      else if (n[i] == best) nbest++;
    xw = 3'(first); xc = 8'(best); xt = nbest > 1;
    tests++; if (winner !== xw) begin fails++; $display("FAIL %s winner: got %0d expected %0d", name, winner, xw); end
    tests++; if (winner_count !== xc) begin fails++; $display("FAIL %s winner_count: got %0d expected %0d", name, winner_count, xc); end
    tests++; if (tie !== xt) begin fails++; $display("FAIL %s tie: got %b expected %b", name, tie, xt); end
    if (rdy) begin
      tick(8'($urandom));
      res_ready = 1'b0;
      tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL %s consume: got valid=%b busy=%b expected 0 0", name, res_valid, busy); end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; win_len = '0; spikes = '0; prev = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({busy, res_valid, winner, winner_count, tie} !== 14'd0) begin fails++; $display("FAIL reset_values: got %h expected 0", {busy, res_valid, winner, winner_count, tie}); end
    rst_n = 1'b1;
    tick(8'h00);
  endtask

  task automatic test_level_single;
    run_window(10, 1, 1'b1, "single_ch3", ew, ec, et);
    if (!EDGE) begin
      tests++; if (winner !== 3'd3 || winner_count !== 8'd10 || tie !== 1'b0) begin fails++; $display("FAIL single_ch3_const: got %0d/%0d/%b expected 3/10/0", winner, winner_count, tie); end
    end
  endtask

  task automatic test_tie;
    run_window(12, 2, 1'b1, "tie_2_5", ew, ec, et);
  endtask

  task automatic test_saturate;
    run_window(0, 3, 1'b1, "saturate", ew, ec, et);
  endtask

  task automatic test_edge_patterns;
    run_window(10, 5, 1'b1, "ch1_const", ew, ec, et);
    run_window(10, 6, 1'b1, "ch1_toggle", ew, ec, et);
    tests++; if (winner !== 3'd1 || winner_count !== 8'd5) begin fails++; $display("FAIL ch1_toggle_const: got %0d/%0d expected 1/5", winner, winner_count); end
  endtask

  task automatic test_all_zero;
    run_window(7, 4, 1'b1, "all_zero", ew, ec, et);
  endtask

  task automatic test_random;
    logic rdy;
    for (int r = 0; r < 10; r++) begin
      rdy = 1'($urandom_range(0, 1));
      run_window(int'($urandom_range(1, 20)), 0, rdy, "random", ew, ec, et);
      if (!rdy) begin
        repeat ($urandom_range(0, 3)) tick(8'($urandom));
        res_ready = 1'b1;
        tick(8'($urandom));
        res_ready = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL random_late_consume: got busy=%b expected 0", busy); end
      end
    end
  endtask

  task automatic test_hold;
    run_window(10, 1, 1'b0, "hold", ew, ec, et);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      win_len = 8'd3;
      tick(8'($urandom));
      tests++; if (res_valid !== 1'b1 || winner !== ew || winner_count !== ec || tie !== et) begin
        fails++; $display("FAIL hold_stable: got v=%b %0d/%0d/%b expected 1 %0d/%0d/%b", res_valid, winner, winner_count, tie, ew, ec, et);
      end
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick(8'h00);
    res_ready = 1'b0;
    tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hold_release: got valid=%b busy=%b expected 0 0", res_valid, busy); end
    repeat (4) tick(8'h00);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_start_ignored: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; win_len = 8'd20;
    tick(8'hFF);
    start = 1'b0;
    repeat (5) tick(8'hFF);
    rst_n = 1'b0;
    spikes = 8'h00;
    #1;
    tests++; if ({busy, res_valid, winner, winner_count, tie} !== 14'd0) begin fails++; $display("FAIL mid_reset_values: got %h expected 0", {busy, res_valid, winner, winner_count, tie}); end
    prev = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) tick(8'h00);
    tests++; if (busy !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL no_partial_result: got busy=%b valid=%b expected 0 0", busy, res_valid); end
    run_window(10, 1, 1'b1, "post_reset", ew, ec, et);
  endtask

  task automatic test_back_to_back;
    run_window(5, 0, 1'b1, "b2b_first", ew, ec, et);
    run_window(6, 0, 1'b1, "b2b_second", ew, ec, et);
  endtask

  initial begin
    test_reset();
    test_level_single();
    test_tie();
    test_saturate();
    test_edge_patterns();
    test_all_zero();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
